// File: rtl/spi_slave_receiver_if.sv
// Bundles the SPI pins and the received-word stream of spi_slave_receiver.
// The slave modport is the receiver's view; the master modport is the SPI/downstream side.
interface spi_slave_receiver_if #(
  parameter int P_DATA_WIDTH = 8
);
  logic                    SCK;
  logic                    CS;
  logic                    MOSI;
  logic [P_DATA_WIDTH-1:0] data_out;
  logic                    valid;
  logic                    ready;
  logic                    overrun;
  logic                    frame_err;

  modport slave (
    input  SCK,
    input  CS,
    input  MOSI,
    input  ready,
    output data_out,
    output valid,
    output overrun,
    output frame_err
  );

  modport master (
    output SCK,
    output CS,
    output MOSI,
    output ready,
    input  data_out,
    input  valid,
    input  overrun,
    input  frame_err
  );
endinterface

// File: rtl/spi_slave_receiver.sv
// SPI slave receiver: oversamples SCK/CS/MOSI on clk_100, assembles MSB-first words and
// presents them on a valid/ready stream with overrun and frame-error pulses.
module spi_slave_receiver #(
  parameter int P_DATA_WIDTH  = 8,
  parameter int P_CPOL        = 0,
  parameter int P_CPHA        = 0,
  parameter int P_SYNC_STAGES = 2
) (
  input  logic                  clk_100,
  input  logic                  a_rst_n,
  spi_slave_receiver_if.slave   bus
);

  localparam int                CNT_W    = $clog2(P_DATA_WIDTH);
  localparam logic              SCK_IDLE = (P_CPOL != 0);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(P_DATA_WIDTH - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Synchronizers, all the same depth so SCK, CS and MOSI stay aligned
  logic [P_SYNC_STAGES-1:0] sck_sync;
  logic [P_SYNC_STAGES-1:0] cs_sync;
  logic [P_SYNC_STAGES-1:0] mosi_sync;
  logic                     sck_s;
  logic                     cs_s;
  logic                     mosi_s;
  logic                     sck_d;

  // NOTE: sequential state is written with non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk_100 or negedge a_rst_n) begin
    if (!a_rst_n) begin
      sck_sync  <= {P_SYNC_STAGES{SCK_IDLE}};
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_d     <= SCK_IDLE;
    end else begin
      sck_sync  <= {sck_sync[P_SYNC_STAGES-2:0], bus.SCK};
      cs_sync   <= {cs_sync[P_SYNC_STAGES-2:0], bus.CS};
      mosi_sync <= {mosi_sync[P_SYNC_STAGES-2:0], bus.MOSI};
      sck_d     <= sck_s;
    end
  end

  assign sck_s  = sck_sync[P_SYNC_STAGES-1];
  assign cs_s   = cs_sync[P_SYNC_STAGES-1];
  assign mosi_s = mosi_sync[P_SYNC_STAGES-1];

  logic rise;
  logic fall;
  logic sample_edge;

  assign rise        = sck_s & ~sck_d;
  assign fall        = ~sck_s & sck_d;
  assign sample_edge = (P_CPOL == P_CPHA) ? rise : fall;

  // Edge strobe, data and CS are registered together so the FSM sees one aligned snapshot
  logic samp_q;
  logic mosi_q;
  logic cs_q;

  always_ff @(posedge clk_100 or negedge a_rst_n) begin
    if (!a_rst_n) begin
      samp_q <= 1'b0;
      mosi_q <= 1'b0;
      cs_q   <= 1'b1;
    end else begin
      samp_q <= sample_edge;
      mosi_q <= mosi_s;
      cs_q   <= cs_s;
    end
  end

  // After reset the CS pipeline holds its reset value, not the pin. The receiver only arms
  // once the pipeline has filled with real samples and CS has been seen high, so a frame
  // already in progress at reset release is never picked up half way.
  logic [P_SYNC_STAGES:0] fill;
  logic                   fill_done;
  logic                   armed;

  assign fill_done = fill[P_SYNC_STAGES];

  always_ff @(posedge clk_100 or negedge a_rst_n) begin
    if (!a_rst_n) begin
      fill  <= '0;
      armed <= 1'b0;
    end else begin
      fill  <= {fill[P_SYNC_STAGES-1:0], 1'b1};
      armed <= armed | (fill_done & cs_q);
    end
  end

  // Word assembly FSM
  state_t                  state;
  state_t                  state_nxt;
  logic [P_DATA_WIDTH-1:0] shift_reg;
  logic [P_DATA_WIDTH-1:0] shift_nxt;
  logic [CNT_W-1:0]        bit_cnt;
  logic [CNT_W-1:0]        cnt_nxt;
  logic [P_DATA_WIDTH-1:0] word;
  logic                    word_done;
  logic                    frame_abort;

  assign word = {shift_reg[P_DATA_WIDTH-2:0], mosi_q};

  always_ff @(posedge clk_100 or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      bit_cnt   <= cnt_nxt;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift_reg;
    cnt_nxt     = bit_cnt;
    word_done   = 1'b0;
    frame_abort = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (armed && !cs_q) begin
          state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        if (cs_q) begin
          // CS release wins over a coincident sample edge; partial bits are discarded
          state_nxt   = IDLE;
          cnt_nxt     = '0;
          shift_nxt   = '0;
          frame_abort = (bit_cnt != '0);
        end else if (samp_q) begin
          shift_nxt = word;
          if (bit_cnt == LAST_BIT) begin
            cnt_nxt   = '0;
            word_done = 1'b1;
          end else begin
            cnt_nxt = bit_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output slot: a completed word loads when the slot is empty or being drained this cycle
  logic [P_DATA_WIDTH-1:0] data_out_r;
  logic                    valid_r;
  logic                    overrun_r;
  logic                    frame_err_r;

  always_ff @(posedge clk_100 or negedge a_rst_n) begin
    if (!a_rst_n) begin
      data_out_r  <= '0;
      valid_r     <= 1'b0;
      overrun_r   <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      overrun_r   <= 1'b0;
      frame_err_r <= frame_abort;
      if (word_done) begin
        if (!valid_r || bus.ready) begin
          data_out_r <= word;
          valid_r    <= 1'b1;
        end else begin
          overrun_r <= 1'b1;
        end
      end else if (valid_r && bus.ready) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign bus.data_out  = data_out_r;
  assign bus.valid     = valid_r;
  assign bus.overrun   = overrun_r;
  assign bus.frame_err = frame_err_r;

endmodule

// File: tb/tb_spi_slave_receiver.sv
// Bench for spi_slave_receiver: one receiver per SPI mode, driven by bit-level SPI tasks,
// with a queue scoreboard popped by a monitor on every valid/ready handshake.
module tb_spi_slave_receiver;

  localparam int SYNC = 2;
  localparam int HALF = 4;  // clk_100 cycles per SCK half period

  logic clk;
  logic rst_n;
  int   cyc = 0;

  logic       sck   [4];
  logic       cs    [4];
  logic       mosi  [4];
  logic       ready [4];
  logic [7:0] dout  [4];
  logic       vld   [4];
  logic       ovr   [4];
  logic       ferr  [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_receiver_if #(.P_DATA_WIDTH(8)) bus ();

    assign bus.SCK   = sck[g];
    assign bus.CS    = cs[g];
    assign bus.MOSI  = mosi[g];
    assign bus.ready = ready[g];
    assign dout[g]   = bus.data_out;
    assign vld[g]    = bus.valid;
    assign ovr[g]    = bus.overrun;
    assign ferr[g]   = bus.frame_err;

    spi_slave_receiver #(
      .P_DATA_WIDTH  (8),
      .P_CPOL        (g / 2),
      .P_CPHA        (g % 2),
      .P_SYNC_STAGES (SYNC)
    ) dut (
      .clk_100 (clk),
      .a_rst_n (rst_n),
      .bus     (bus.slave)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q [4][$];
  int         exp_ferr [4];
  int         exp_ovr  [4];
  int         ferr_cnt [4];
  int         ovr_cnt  [4];
  int         vhigh_cnt[4];
  int         rise_cyc [4];
  int         edge_cyc [4];
  event       word_edge;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change 2 time units after the rising edge, outputs are read on the falling edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic monitor();
    logic       prev_v [4];
    logic       prev_r [4];
    logic [7:0] prev_d [4];
    logic [7:0] exp_w;
    for (int m = 0; m < 4; m++) prev_v[m] = 1'b0;
    forever begin
      @(negedge clk);
      for (int m = 0; m < 4; m++) begin
        if (!rst_n) begin
          prev_v[m] = 1'b0;
        end else begin
          if (vld[m]) vhigh_cnt[m]++;
          if (vld[m] && !prev_v[m]) rise_cyc[m] = cyc;
          if (ovr[m]) ovr_cnt[m]++;
          if (ferr[m]) ferr_cnt[m]++;
          if (prev_v[m] && !prev_r[m]) begin
            check($sformatf("hold_valid_m%0d", m), {31'd0, vld[m]}, 32'd1);
            check($sformatf("hold_data_m%0d", m), {24'd0, dout[m]}, {24'd0, prev_d[m]});
          end
          if (vld[m] && ready[m]) begin
            if (exp_q[m].size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_word_m%0d: got %0h expected none", m, dout[m]);
            end else begin
              exp_w = exp_q[m].pop_front();
              check($sformatf("word_m%0d", m), {24'd0, dout[m]}, {24'd0, exp_w});
            end
          end
          prev_v[m] = vld[m];
          prev_r[m] = ready[m];
          prev_d[m] = dout[m];
        end
      end
    end
  endtask

  // Sends the first nbits of w, MSB first; mode m = {CPOL, CPHA}
  task automatic send_word(input int m, input logic [7:0] w, input int nbits);
    logic b;
    for (int i = 0; i < nbits; i++) begin
      b = w[7-i];
      if (m % 2 == 0) begin
        mosi[m] = b;
        tick(HALF);
        sck[m] = (m / 2 == 0);
        edge_cyc[m] = cyc;
        if (i == 7) ->word_edge;
        tick(HALF);
        sck[m] = (m / 2 != 0);
      end else begin
        sck[m]  = (m / 2 == 0);
        mosi[m] = b;
        tick(HALF);
        sck[m] = (m / 2 != 0);
        edge_cyc[m] = cyc;
        if (i == 7) ->word_edge;
        tick(HALF);
      end
    end
  endtask

  task automatic cs_low(input int m);
    cs[m] = 1'b0;
    tick(HALF);
  endtask

  task automatic cs_high(input int m);
    tick(HALF);
    cs[m] = 1'b1;
    tick(2 * HALF);
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      check($sformatf("%s_data_m%0d", tag, m), {24'd0, dout[m]}, 32'd0);
      check($sformatf("%s_valid_m%0d", tag, m), {31'd0, vld[m]}, 32'd0);
      check($sformatf("%s_overrun_m%0d", tag, m), {31'd0, ovr[m]}, 32'd0);
      check($sformatf("%s_frame_err_m%0d", tag, m), {31'd0, ferr[m]}, 32'd0);
    end
  endtask

  initial begin
    int         v0;
    int         nw;
    logic [7:0] w;

    for (int m = 0; m < 4; m++) begin
      sck[m]       = (m / 2 != 0);
      cs[m]        = 1'b1;
      mosi[m]      = 1'b0;
      ready[m]     = 1'b1;
      exp_ferr[m]  = 0;
      exp_ovr[m]   = 0;
      ferr_cnt[m]  = 0;
      ovr_cnt[m]   = 0;
      vhigh_cnt[m] = 0;
      rise_cyc[m]  = 0;
      edge_cyc[m]  = 0;
    end
    rst_n = 1'b0;

    fork
      monitor();
      begin
        forever begin
          @(posedge clk);
          if (cyc > 90000) begin
            $display("FAIL watchdog: got %0d cycles expected under 90000", cyc);
            $fatal(1, "bench did not complete");
          end
        end
      end
    join_none

    tick(3);
    check_reset_outputs("reset");
    tick(1);
    rst_n = 1'b1;
    tick(10);

    // T1: mode 0, 0xA5, ready high: single-cycle valid, fixed latency
    v0 = vhigh_cnt[0];
    exp_q[0].push_back(8'hA5);
    cs_low(0);
    send_word(0, 8'hA5, 8);
    cs_high(0);
    check("t1_latency", rise_cyc[0] - edge_cyc[0], SYNC + 2);
    check("t1_valid_cycles", vhigh_cnt[0] - v0, 1);
    check("t1_drained", exp_q[0].size(), 0);

    // T2: modes 1..3, two words back to back in one frame
    for (int m = 1; m < 4; m++) begin
      exp_q[m].push_back(8'h3C);
      exp_q[m].push_back(8'hC3);
      cs_low(m);
      send_word(m, 8'h3C, 8);
      send_word(m, 8'hC3, 8);
      cs_high(m);
      check($sformatf("t2_drained_m%0d", m), exp_q[m].size(), 0);
      check($sformatf("t2_frame_err_m%0d", m), ferr_cnt[m], exp_ferr[m]);
    end

    // T3: ready low, second word is lost and flagged
    ready[0] = 1'b0;
    exp_q[0].push_back(8'h11);
    exp_ovr[0]++;
    cs_low(0);
    send_word(0, 8'h11, 8);
    send_word(0, 8'h22, 8);
    cs_high(0);
    @(negedge clk);
    check("t3_data_held", {24'd0, dout[0]}, 32'h11);
    check("t3_valid_held", {31'd0, vld[0]}, 32'd1);
    check("t3_overrun_count", ovr_cnt[0], exp_ovr[0]);
    tick(1);
    ready[0] = 1'b1;
    tick(3);
    check("t3_drained", exp_q[0].size(), 0);
    tick(20);
    @(negedge clk);
    check("t3_valid_clear", {31'd0, vld[0]}, 32'd0);
    tick(1);

    // T4: CS released after 5 bits, then a clean word
    exp_ferr[0]++;
    cs_low(0);
    send_word(0, 8'hFF, 5);
    cs_high(0);
    exp_q[0].push_back(8'h5A);
    cs_low(0);
    send_word(0, 8'h5A, 8);
    cs_high(0);
    check("t4_frame_err_count", ferr_cnt[0], exp_ferr[0]);
    check("t4_drained", exp_q[0].size(), 0);

    // T5: new word completes in the very cycle the held word is accepted
    ready[0] = 1'b0;
    exp_q[0].push_back(8'h69);
    exp_q[0].push_back(8'h96);
    cs_low(0);
    send_word(0, 8'h69, 8);
    fork
      send_word(0, 8'h96, 8);
      begin
        @(word_edge);
        tick(SYNC + 1);
        ready[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t5_valid_kept", {31'd0, vld[0]}, 32'd1);
        check("t5_new_data", {24'd0, dout[0]}, 32'h96);
      end
    join
    cs_high(0);
    check("t5_overrun_count", ovr_cnt[0], exp_ovr[0]);
    check("t5_drained", exp_q[0].size(), 0);

    // T6: reset mid-word, released while CS is still low
    cs_low(0);
    send_word(0, 8'hF0, 4);
    rst_n = 1'b0;
    tick(2);
    check_reset_outputs("midreset");
    tick(1);
    rst_n = 1'b1;
    tick(2);
    send_word(0, 8'h0F, 4);
    cs_high(0);
    exp_q[0].push_back(8'h81);
    cs_low(0);
    send_word(0, 8'h81, 8);
    cs_high(0);
    check("t6_drained", exp_q[0].size(), 0);
    check("t6_frame_err_count", ferr_cnt[0], exp_ferr[0]);
    check("t6_overrun_count", ovr_cnt[0], exp_ovr[0]);

    // Random frames in every mode: random word counts, values and trailing partial words
    for (int m = 0; m < 4; m++) begin
      for (int f = 0; f < 6; f++) begin
        nw = $urandom_range(1, 3);
        cs_low(m);
        for (int k = 0; k < nw; k++) begin
          w = 8'($urandom);
          exp_q[m].push_back(w);
          send_word(m, w, 8);
        end
        if ($urandom_range(0, 2) == 0) begin
          exp_ferr[m]++;
          send_word(m, 8'($urandom), $urandom_range(1, 7));
        end
        cs_high(m);
      end
      tick(10);
      check($sformatf("rand_drained_m%0d", m), exp_q[m].size(), 0);
      check($sformatf("rand_frame_err_m%0d", m), ferr_cnt[m], exp_ferr[m]);
      check($sformatf("rand_overrun_m%0d", m), ovr_cnt[m], exp_ovr[m]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
